// File: rtl/gelu_stream_ctrl_if.sv
// rtl/gelu_stream_ctrl_if.sv - stream and datapath signal bundle for gelu_stream_ctrl
interface gelu_stream_ctrl_if;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_x;
    logic [2:0] s_scale;
    logic [7:0] g_x;
    logic [2:0] g_in_scale;
    logic [7:0] g_y;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_y;
    logic [2:0] m_scale;
    logic       busy;

    // controller side
    modport slave (
        input  s_valid, s_x, s_scale, g_y, m_ready,
        output s_ready, g_x, g_in_scale, m_valid, m_y, m_scale, busy
    );

    // upstream/downstream/datapath environment side
    modport master (
        output s_valid, s_x, s_scale, g_y, m_ready,
        input  s_ready, g_x, g_in_scale, m_valid, m_y, m_scale, busy
    );
endinterface

// File: rtl/gelu_stream_ctrl.sv
// rtl/gelu_stream_ctrl.sv - flow control around a fixed-latency gelu datapath with an output FIFO
module gelu_stream_ctrl #(
    parameter int LAT   = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    gelu_stream_ctrl_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < LAT + 2) begin : g_bad_depth
        $error("gelu_stream_ctrl: DEPTH must be at least LAT+2");
    end

    logic [7:0]          g_x_q;
    logic [2:0]          g_sc_q;
    logic [LAT:0]        vld_q;
    logic [LAT:0][2:0]   sc_pipe_q;
    logic [7:0]          mem_y_q  [DEPTH];
    logic [2:0]          mem_sc_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       inflight;
    logic                s_fire, m_fire, push;

    assign s_fire = bus.s_valid & bus.s_ready;
    assign m_fire = bus.m_valid & bus.m_ready;
    // the oldest stage lines up with g_y for the operand issued LAT cycles ago
    assign push   = vld_q[LAT];

    // count operands travelling through the datapath
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LAT; i++) begin
            inflight = inflight + CW'(vld_q[i]);
        end
    end

    // reserve FIFO space for everything in flight; a same-cycle pop is deliberately not credited
    assign bus.s_ready = rst_n & (((CW+1)'(cnt_q) + (CW+1)'(inflight)) < (CW+1)'(DEPTH));

    // operand register feeding the datapath, held between transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_x_q  <= '0;
            g_sc_q <= '0;
        end else if (s_fire) begin
            g_x_q  <= bus.s_x;
            g_sc_q <= bus.s_scale;
        end
    end

    // valid and scale shadow of the datapath pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            sc_pipe_q <= '0;
        end else begin
            vld_q     <= {vld_q[LAT-1:0], s_fire};
            sc_pipe_q <= {sc_pipe_q[LAT-1:0], bus.s_scale};
        end
    end

    // next-state for FIFO pointers and occupancy, wrapping modulo DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (m_fire) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, m_fire})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO storage; contents are only observed through a valid head entry
    always_ff @(posedge clk) begin
        if (push) begin
            mem_y_q[wr_ptr_q]  <= bus.g_y;
            mem_sc_q[wr_ptr_q] <= sc_pipe_q[LAT];
        end
    end

    assign bus.g_x        = g_x_q;
    assign bus.g_in_scale = g_sc_q;
    assign bus.m_valid    = (cnt_q != '0);
    assign bus.m_y        = bus.m_valid ? mem_y_q[rd_ptr_q]  : 8'h00;
    assign bus.m_scale    = bus.m_valid ? mem_sc_q[rd_ptr_q] : 3'd0;
    assign bus.busy       = (inflight != '0) | (cnt_q != '0);
endmodule

// File: doc/gelu_stream_ctrl.md
GELU_STREAM_CTRL -- requirements
Module: gelu_stream_ctrl

Interface
REQ-001 The block SHALL have parameter LAT, default 8: fixed latency, in cycles, of the attached gelu datapath.
REQ-002 The block SHALL have parameter DEPTH, default 16: output FIFO depth; legal only if DEPTH >= LAT+2.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port s_valid, input, 1 bit: upstream operand valid.
REQ-006 The block SHALL have port s_ready, output, 1 bit: block can accept an operand.
REQ-007 The block SHALL have port s_x, input, 8 bits: signed operand, fixed point.
REQ-008 The block SHALL have port s_scale, input, 3 bits: fractional bits of s_x.
REQ-009 The block SHALL have port g_x, output, 8 bits: operand driven to the gelu datapath.
REQ-010 The block SHALL have port g_in_scale, output, 3 bits: scale driven to the gelu datapath.
REQ-011 The block SHALL have port g_y, input, 8 bits: gelu datapath result.
REQ-012 The block SHALL have port m_valid, output, 1 bit: result available downstream.
REQ-013 The block SHALL have port m_ready, input, 1 bit: downstream accepts the result.
REQ-014 The block SHALL have port m_y, output, 8 bits: signed result.
REQ-015 The block SHALL have port m_scale, output, 3 bits: scale that travelled with the result.
REQ-016 The block SHALL have port busy, output, 1 bit: at least one operand in flight or buffered.

Function
REQ-017 An input transfer SHALL occur in a cycle only when s_valid=1 and s_ready=1; an output transfer only when m_valid=1 and m_ready=1.
REQ-018 On an input transfer, g_x and g_in_scale SHALL be registered from s_x and s_scale; otherwise they SHALL hold their last value.
REQ-019 The block SHALL treat g_y as the result of the g_x value present exactly LAT cycles earlier, and SHALL track it with a (LAT+1)-stage valid and scale shift register.
REQ-020 When the last valid stage is set, the block SHALL write g_y and its matching scale into the FIFO in that cycle.
REQ-021 Input-transfer to m_valid latency SHALL be LAT+2 cycles (10 at defaults) with an empty FIFO.
REQ-022 Inflight SHALL equal the count of set valid stages; s_ready SHALL be 1 iff (fifo_count + inflight) < DEPTH.
REQ-023 The s_ready computation SHALL NOT credit a same-cycle output pop, so the FIFO never overflows and no result is dropped.
REQ-024 The FIFO SHALL preserve order; m_valid SHALL be 1 iff fifo_count > 0, with m_y/m_scale showing the head entry.
REQ-025 m_y and m_scale SHALL be stable while m_valid=1 and m_ready=0.
REQ-026 The FIFO SHALL support simultaneous push and pop in one cycle, leaving the count unchanged.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH, with no bubbles at the wrap.
REQ-028 With m_ready held at 1, the block SHALL sustain one transfer per cycle and s_ready SHALL stay at 1.
REQ-029 busy SHALL be 1 iff inflight > 0 or fifo_count > 0.

Reset
REQ-030 While rst_n=0, all valid stages, FIFO pointers and count SHALL clear; m_valid=0, busy=0, g_x=0, g_in_scale=0, m_y=0, m_scale=0.
REQ-031 s_ready SHALL be 0 during reset and 1 in the first cycle after release.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight and buffered results; none SHALL appear after release.

Verification
REQ-033 Single op: s_x=8'h10, s_scale=2 in cycle 0, gelu model with LAT=8 -> m_valid=1 in cycle 10 with m_y equal to the model output for 4.0 at scale 2, m_scale=2.
REQ-034 Backpressure: m_ready=0, 20 back-to-back offers -> exactly 16 accepted, then s_ready=0; release m_ready -> 16 results in input order, no loss or duplication.
REQ-035 Throughput: m_ready=1, 100 consecutive random operands -> s_ready never drops; one result per cycle from cycle 10 to cycle 109.
REQ-036 Full FIFO with push and pop: fifo_count=DEPTH-LAT-1, inflight=LAT+1, m_ready toggled every cycle -> count never exceeds 16, no dropped result.
REQ-037 Reset mid-run: rst_n low for 1 cycle with 5 in flight and 3 buffered -> m_valid=0, busy=0 immediately, s_ready=1 after release, no stale outputs.
REQ-038 Random stimulus: 10k random transfers with random s_valid/m_ready -> scoreboard matches every m_y/m_scale pair in order.
